// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-lane bus RAM.
package ram_pkg;

  localparam int unsigned LANE_WIDTH     = 8;
  // Upper bound on word width accepted by lane_merge; callers zero-extend and truncate.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_LANES      = MAX_DATA_WIDTH / LANE_WIDTH;

  typedef enum logic [0:0] {
    RAM_CLEAR,
    RAM_RUN
  } ram_state_t;

  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      we
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (we[i]) res[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_ram_if.sv
// Valid/ready request/response bundle between a bus master and bus_ram.
interface bus_ram_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14
);
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic [LANES-1:0]      req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_core.sv
// Inferred single-port byte-lane RAM with a registered read port.
module ram_core
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned READ_FIRST = 1
) (
  input  logic                             clk_i,
  input  logic                             en_i,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o
);
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] merged;

  assign merged = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem_q[addr_i]),
                                         MAX_DATA_WIDTH'(wdata_i),
                                         MAX_LANES'(we_i)));

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) rdata_d = (READ_FIRST != 0) ? mem_q[addr_i] : merged;
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (en_i) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (we_i[i]) mem_q[addr_i][i*LANE_WIDTH +: LANE_WIDTH] <= wdata_i[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// Valid/ready word RAM: power-up clear FSM, range check and a stallable 1- or 2-stage pipeline.
module bus_ram
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned READ_FIRST     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_ram_if.slave       bus,
  output logic           busy
);
  localparam int unsigned LANES      = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  v1_q, v1_d;
  logic                  oob1_q, oob1_d;

  logic                  clearing, accept, in_range, s1_advance;
  logic                  core_en;
  logic [LANES-1:0]      core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata, core_rdata, s1_data;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      RAM_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) state_d = RAM_RUN;
      end
      RAM_RUN: ;
    endcase
  end

  assign clearing = (state_q == RAM_CLEAR);
  assign busy     = clearing;
  assign in_range = (ADDR_WIDTH + 1)'(bus.req_addr) < (ADDR_WIDTH + 1)'(DEPTH);

  // rst_n gates ready so nothing is accepted while reset is held in the RUN state.
  assign bus.req_ready = rst_n && (state_q == RAM_RUN) && (!v1_q || s1_advance);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    v1_d   = v1_q;
    oob1_d = oob1_q;
    if (accept) begin
      v1_d   = 1'b1;
      oob1_d = !in_range;
    end else if (s1_advance) begin
      v1_d   = 1'b0;
    end
  end

  // The array is only enabled on a fresh in-range accept, so stalled data is never re-read.
  assign core_en    = clearing || (accept && in_range);
  assign core_we    = clearing ? '1 : bus.req_we;
  assign core_addr  = clearing ? clr_cnt_q : bus.req_addr;
  assign core_wdata = clearing ? '0 : bus.req_wdata;
  assign s1_data    = oob1_q ? '0 : core_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;
      clr_cnt_q <= '0;
      v1_q      <= 1'b0;
      oob1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      v1_q      <= v1_d;
      oob1_q    <= oob1_d;
    end
  end

  ram_core #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_FIRST (READ_FIRST)
  ) u_core (
    .clk_i   (clk),
    .en_i    (core_en),
    .we_i    (core_we),
    .addr_i  (core_addr),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] d2_q, d2_d;

    always_comb begin
      s1_advance = !v2_q || bus.rsp_ready;
      v2_d       = v2_q;
      d2_d       = d2_q;
      if (s1_advance) begin
        v2_d = v1_q;
        if (v1_q) d2_d = s1_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign bus.rsp_valid = v2_q;
    assign bus.rsp_data  = v2_q ? d2_q : '0;
  end else begin : g_no_out_reg
    assign s1_advance    = bus.rsp_ready;
    assign bus.rsp_valid = v1_q;
    assign bus.rsp_data  = v1_q ? s1_data : '0;
  end

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench: instance A (DEPTH=16, OUT_REG=1, READ_FIRST=1), B (DEPTH=12, OUT_REG=0, READ_FIRST=0).
module tb_bus_ram;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n, sel;
  logic        req_valid, rsp_ready;
  logic [3:0]  req_we, req_addr;
  logic [31:0] req_wdata;
  logic        busy_a, busy_b;
  logic        o_rdy, o_rv;
  logic [31:0] o_rd;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bus_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia ();
  bus_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib ();

  assign ia.req_valid = req_valid && !sel;
  assign ia.req_we    = req_we;
  assign ia.req_addr  = req_addr;
  assign ia.req_wdata = req_wdata;
  assign ia.rsp_ready = rsp_ready;
  assign ib.req_valid = req_valid && sel;
  assign ib.req_we    = req_we;
  assign ib.req_addr  = req_addr;
  assign ib.req_wdata = req_wdata;
  assign ib.rsp_ready = rsp_ready;

  assign o_rdy = sel ? ib.req_ready : ia.req_ready;
  assign o_rv  = sel ? ib.rsp_valid : ia.rsp_valid;
  assign o_rd  = sel ? ib.rsp_data  : ia.rsp_data;

  bus_ram #(.DEPTH(16), .DATA_WIDTH(32), .OUT_REG(1), .READ_FIRST(1), .CLEAR_ON_RESET(1)) u_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ia),
    .busy  (busy_a)
  );

  bus_ram #(.DEPTH(12), .DATA_WIDTH(32), .OUT_REG(0), .READ_FIRST(0), .CLEAR_ON_RESET(1)) u_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ib),
    .busy  (busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] patt(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Single request, then wait for and consume its response; lat counts edges from accept.
  task automatic xact(input logic [3:0] we, input int addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    int n = 0;
    req_we = we; req_addr = 4'(addr); req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    while (!o_rdy && n < 50) begin step(); n++; end
    check("accept_wait", 32'(n < 50), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!o_rv && lat < 50) begin step(); lat++; end
    rd = o_rd;
    step();
  endtask

  // Eight back-to-back reads of addresses 0..7, optionally stalling 5 cycles after 3 responses.
  task automatic stream(input bit stall, output int first, output int last);
    int issue = 0, got = 0, cyc = 0, stall_left = 0;
    bit stall_done = 1'b0;
    logic acc;
    logic [31:0] held = '0;
    first = -1; last = -1;
    req_we = '0; req_addr = '0; req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    acc = req_valid && o_rdy;
    while (got < 8 && cyc < 60) begin
      step();
      cyc++;
      if (acc) issue++;
      if (stall && got == 3 && !stall_done) begin
        stall_left = 5; stall_done = 1'b1; held = o_rd;
      end
      rsp_ready = (stall_left == 0);
      if (stall_left > 0) begin
        check("stall_valid", 32'(o_rv), 32'd1);
        check("stall_data", o_rd, held);
        stall_left--;
      end else if (o_rv) begin
        check("stream_data", o_rd, patt(got));
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
      req_valid = (issue < 8);
      req_addr  = 4'(issue);
      #1;
      acc = req_valid && o_rdy;
      if (!rsp_ready) check("stall_req_ready", 32'(o_rdy), 32'd0);
    end
    check("stream_count", 32'(got), 32'd8);
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    check("stream_tail", 32'(o_rv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1);
  end

  initial begin
    int n, lat, first, last;
    logic [31:0] rd;
    sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_valid = 1'b0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) step();
    check("rst_rsp_valid", 32'(ia.rsp_valid), 32'd0);
    check("rst_rsp_data", ia.rsp_data, 32'd0);
    check("rst_req_ready", 32'(ia.req_ready), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd1);

    rst_a_n = 1'b1; rst_b_n = 1'b1;
    n = 0;
    while (busy_a && n < 40) begin n++; step(); end
    check("clear_len", 32'(n), 32'd16);
    check("ready_after_clear", 32'(ia.req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      xact(4'b0000, i, 32'h0, rd, lat);
      check("clear_read", rd, 32'h0);
      if (i == 0) check("lat_out_reg", 32'(lat), 32'd2);
    end

    xact(4'b1111, 5, 32'hDEAD_BEEF, rd, lat);
    check("a_wr1_rsp", rd, 32'h0000_0000);
    xact(4'b0100, 5, 32'h00AA_0000, rd, lat);
    check("a_wr2_rsp_old", rd, 32'hDEAD_BEEF);
    xact(4'b0000, 5, 32'h0, rd, lat);
    check("a_rd_merged", rd, 32'hDEAA_BEEF);

    for (int i = 0; i < 8; i++) xact(4'b1111, i, patt(i), rd, lat);
    stream(1'b0, first, last);
    check("stream_first", 32'(first), 32'd2);
    check("stream_span", 32'(last - first), 32'd7);
    stream(1'b1, first, last);
    check("stall_first", 32'(first), 32'd2);
    check("stall_span", 32'(last - first), 32'd12);

    sel = 1'b1;
    xact(4'b0000, 3, 32'h0, rd, lat);
    check("b_clear_read", rd, 32'h0);
    check("lat_no_out_reg", 32'(lat), 32'd1);
    for (int i = 0; i < 12; i++) begin
      xact(4'b1111, i, 32'hB000_0000 + 32'(i), rd, lat);
      check("b_wr_rsp_new", rd, 32'hB000_0000 + 32'(i));
    end
    xact(4'b1111, 5, 32'hDEAD_BEEF, rd, lat);
    check("b_wr1_rsp", rd, 32'hDEAD_BEEF);
    xact(4'b0100, 5, 32'h00AA_0000, rd, lat);
    check("b_wr2_rsp_merged", rd, 32'hDEAA_BEEF);
    xact(4'b1111, 13, 32'h1234_5678, rd, lat);
    check("b_oob_wr_rsp", rd, 32'h0);
    xact(4'b0000, 13, 32'h0, rd, lat);
    check("b_oob_rd", rd, 32'h0);
    for (int i = 0; i < 12; i++) begin
      xact(4'b0000, i, 32'h0, rd, lat);
      check("b_readback", rd, (i == 5) ? 32'hDEAA_BEEF : 32'hB000_0000 + 32'(i));
    end

    sel = 1'b0;
    rst_a_n = 1'b0;
    step();
    rst_a_n = 1'b1;
    repeat (7) step();
    check("mid_clear_busy", 32'(busy_a), 32'd1);
    rst_a_n = 1'b0;
    step();
    step();
    check("reclear_busy", 32'(busy_a), 32'd1);
    check("reclear_valid", 32'(ia.rsp_valid), 32'd0);
    rst_a_n = 1'b1;
    n = 0;
    while (busy_a && n < 40) begin
      check("reclear_valid_run", 32'(ia.rsp_valid), 32'd0);
      n++;
      step();
    end
    check("reclear_len", 32'(n), 32'd16);
    xact(4'b0000, 5, 32'h0, rd, lat);
    check("reclear_read", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
